// File: rtl/wave_capture.sv
// Ping-pong capture of audio samples for the wave display: arms on a rising zero
// crossing, stores one frame into the bank the display is not reading, then flips on idle.
module wave_capture #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_WIDTH   = 9,
  parameter int VALUE_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic                    wave_display_idle,
  output logic [ADDR_WIDTH-1:0]   write_address,
  output logic                    write_enable,
  output logic [VALUE_WIDTH-1:0]  write_sample,
  output logic                    read_index
);
  localparam int IW = ADDR_WIDTH - 1;

  typedef enum logic [1:0] {S_ARMED, S_ACTIVE, S_WAIT} state_e;

  state_e                  state_q;
  logic [IW-1:0]           index_q;
  logic [SAMPLE_WIDTH-1:0] prev_q;
  logic                    read_index_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [VALUE_WIDTH-1:0]  wsample_q;

  logic                    crossing;
  logic                    store;
  logic [IW-1:0]           store_idx;
  logic [VALUE_WIDTH-1:0]  value_d;

  assign crossing = new_sample_ready && prev_q[SAMPLE_WIDTH-1] && !new_sample_in[SAMPLE_WIDTH-1];

  always_comb begin
    store     = 1'b0;
    store_idx = index_q;
    case (state_q)
      S_ARMED: begin
        store     = crossing;
        store_idx = '0;
      end
      S_ACTIVE: store = new_sample_ready;
      default:  store = 1'b0;
    endcase
    // Offset-binary: flip the sign bit so the most negative sample maps to 0.
    value_d = {~new_sample_in[SAMPLE_WIDTH-1], new_sample_in[SAMPLE_WIDTH-2 -: VALUE_WIDTH-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_ARMED;
      index_q      <= '0;
      prev_q       <= '0;
      read_index_q <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wsample_q    <= '0;
    end else begin
      we_q <= store;
      if (new_sample_ready) prev_q <= new_sample_in;
      if (store) begin
        waddr_q   <= {~read_index_q, store_idx};
        wsample_q <= value_d;
        index_q   <= store_idx + IW'(1);
      end
      case (state_q)
        S_ARMED:  if (crossing) state_q <= S_ACTIVE;
        S_ACTIVE: if (new_sample_ready && index_q == {IW{1'b1}}) state_q <= S_WAIT;
        S_WAIT: begin
          if (wave_display_idle) begin
            read_index_q <= ~read_index_q;
            state_q      <= S_ARMED;
          end
        end
        default: state_q <= S_ARMED;
      endcase
    end
  end

  assign write_address = waddr_q;
  assign write_enable  = we_q;
  assign write_sample  = wsample_q;
  assign read_index    = read_index_q;
endmodule
